led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised LED driver. Advances an LED pattern once every WAIT_TIME+1 clocks in one of four selectable modes: binary up, binary down, bounce and Gray count. Supports pause and single-step. Sits between the board clock/reset and the LED pins; also exports a tick strobe that other blocks can use as a slow enable.

Parameters:
WAIT_TIME, 1048576, clocks per pattern step minus one (tick period = WAIT_TIME+1); legal range >= 1
LED_COUNT, 6, number of LEDs / pattern width; legal range 1..32
ACTIVE_LOW, 1, 1 = out_led is the bitwise inverse of the pattern; 0 = out_led is the pattern directly

Ports:
in_clk  input  1  system clock; all state on rising edge
in_rst  input  1  asynchronous, active-high reset
in_mode  input  2  0=binary up, 1=binary down, 2=bounce, 3=Gray up
in_pause  input  1  level; 1 = hold the tick counter and pattern
in_step  input  1  one-cycle pulse; advances the pattern once while paused
out_led  output  LED_COUNT  LED drive, polarity per ACTIVE_LOW
out_tick  output  1  one-cycle strobe on every pattern advance

Behaviour:
- Reset: one clock (in_clk); asynchronous active-high reset (in_rst). While in_rst=1, all registers clear immediately, independent of the clock:
  - tick counter = 0, binary accumulator = 0, bounce position = bit0, bounce direction = up
  - registered mode = 0, out_tick = 0
  - pattern = 0, so out_led = all-ones if ACTIVE_LOW=1, all-zeros otherwise
- Tick counter:
  - width $clog2(WAIT_TIME+1)
  - counts 0..WAIT_TIME while not paused; at an edge where it equals WAIT_TIME it loads 0 and an advance occurs
  - first advance after reset release happens on the (WAIT_TIME+1)th rising edge
- Advance: pattern register, tick counter and out_tick update on the same edge; out_tick is high for exactly one cycle after each advance.
- Pattern per mode, computed on advance, with wrap-around:
  - up: acc+1, wraps all-ones -> 0; pattern = acc
  - down: acc-1, wraps 0 -> all-ones; pattern = acc
  - bounce: one-hot position moves toward the current direction. At bit LED_COUNT-1 the direction flips to down and the next step goes to LED_COUNT-2; at bit0 it flips to up. Each end is shown for one period (no double dwell). LED_COUNT=1: pattern stays 1.
  - Gray: acc+1 with the same wrap as up; pattern = acc ^ (acc>>1)
- Mode change:
  - in_mode is registered every cycle.
  - When the sampled in_mode differs from the registered mode, on that edge: registered mode updates, tick counter clears to 0, out_tick = 0.
  - State loads the new mode's start value: up/Gray acc=0; down acc=all-ones; bounce position=bit0, direction=up.
  - No advance occurs on a mode-change edge, even if the counter was at WAIT_TIME.
- Pause:
  - in_pause=1 freezes the tick counter and pattern.
  - in_step=1 while paused gives exactly one advance on that edge (out_tick pulses) and clears the tick counter.
  - in_step while not paused is ignored.
  - Releasing pause resumes counting from the held count.
- Priority, highest first: reset > mode change > step/tick advance > hold.
- Reset asserted mid-operation: outputs return to reset values asynchronously. After release, timing restarts from count 0.

Test Plan:
- WAIT_TIME=3, LED_COUNT=4, ACTIVE_LOW=1, mode 0, release reset -> out_led=4'b1111 for 4 edges; 4'b1110 after edge 4; out_tick high only in cycles 5, 9, 13...
- Mode 1 from reset, WAIT_TIME=3 -> pattern after mode change is 4'hF; advances give E, D, ...; 0 -> F wrap verified after 16 advances.
- Mode 2, LED_COUNT=4 -> pattern sequence 1,2,4,8,4,2,1,2; LED_COUNT=1 -> pattern constantly 1.
- Mode 3 -> patterns 0,1,3,2,6,7,5,4,C,... and exactly one bit changes per advance.
- Pause at count 2, hold 20 cycles -> no change and no out_tick. Pulse in_step -> exactly one advance plus one out_tick. Step with pause=0 -> no extra advance.
- Change mode on an edge where the counter = WAIT_TIME -> no advance, no out_tick, counter=0, start pattern shown. Assert in_rst mid-period (between clock edges) -> out_led goes all-ones immediately.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: binary up/down, bounce and Gray count.
// Advances once per WAIT_TIME+1 clocks, with pause and single-step.
module led_pattern_gen #(
  parameter int WAIT_TIME  = 1048576,
  parameter int LED_COUNT  = 6,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic [1:0]           in_mode,
  input  logic                 in_pause,
  input  logic                 in_step,
  output logic [LED_COUNT-1:0] out_led,
  output logic                 out_tick
);

  localparam int CW = $clog2(WAIT_TIME + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_TIME);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [LED_COUNT-1:0] ONES = '1;
  localparam logic [LED_COUNT-1:0] ONE  = LED_COUNT'(1);
  localparam logic [LED_COUNT-1:0] TOP  = ONE << (LED_COUNT - 1);

  typedef enum logic [1:0] {
    M_UP   = 2'd0,
    M_DN   = 2'd1,
    M_BNC  = 2'd2,
    M_GRAY = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LED_COUNT-1:0] acc_q, acc_d;
  logic [LED_COUNT-1:0] pos_q, pos_d;
  logic [LED_COUNT-1:0] pat_q, pat_d;
  dir_t                 dir_q, dir_d;
  mode_t                mode_q, mode_d;
  logic                 tick_q, tick_d;

  logic                 mode_chg;
  logic                 adv;
  logic [LED_COUNT-1:0] acc_inc;
  logic [LED_COUNT-1:0] acc_dec;
  logic [LED_COUNT-1:0] pos_nx;
  dir_t                 dir_nx;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      pos_q  <= ONE;
      dir_q  <= DIR_UP;
      mode_q <= M_UP;
      pat_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      pat_q  <= pat_d;
      tick_q <= tick_d;
    end
  end

  // Bounce: direction flips on arrival at an end, so each end dwells once.
  always_comb begin
    pos_nx = pos_q;
    dir_nx = dir_q;
    if (LED_COUNT == 1) begin
      pos_nx = ONE;
      dir_nx = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      pos_nx = pos_q << 1;
      dir_nx = (pos_nx == TOP) ? DIR_DN : DIR_UP;
    end else begin
      pos_nx = pos_q >> 1;
      dir_nx = (pos_nx == ONE) ? DIR_UP : DIR_DN;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    pat_d    = pat_q;
    tick_d   = 1'b0;
    acc_inc  = acc_q + ONE;
    acc_dec  = acc_q - ONE;
    mode_chg = (mode_t'(in_mode) != mode_q);
    adv      = in_pause ? in_step : (cnt_q == CNT_MAX);

    if (mode_chg) begin
      mode_d = mode_t'(in_mode);
      cnt_d  = '0;
      pos_d  = ONE;
      dir_d  = DIR_UP;
      unique case (mode_t'(in_mode))
        M_UP: begin
          acc_d = '0;
          pat_d = '0;
        end
        M_DN: begin
          acc_d = ONES;
          pat_d = ONES;
        end
        M_BNC: begin
          acc_d = acc_q;
          pat_d = ONE;
        end
        M_GRAY: begin
          acc_d = '0;
          pat_d = '0;
        end
        default: ;
      endcase
    end else if (adv) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      unique case (mode_q)
        M_UP: begin
          acc_d = acc_inc;
          pat_d = acc_inc;
        end
        M_DN: begin
          acc_d = acc_dec;
          pat_d = acc_dec;
        end
        M_BNC: begin
          pos_d = pos_nx;
          dir_d = dir_nx;
          pat_d = pos_nx;
        end
        M_GRAY: begin
          acc_d = acc_inc;
          pat_d = acc_inc ^ (acc_inc >> 1);
        end
        default: ;
      endcase
    end else if (!in_pause) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign out_led  = ACTIVE_LOW ? ~pat_q : pat_q;
  assign out_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed phases plus random pause/step/mode
// traffic, checked against a pattern-index model.
module tb_led_pattern_gen;

  localparam int W = 3;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       pause;
  logic       step;
  logic [3:0] led_a;
  logic       tick_a;
  logic [0:0] led_b;
  logic       tick_b;

  int tests;
  int fails;

  int mm;
  int mk;
  int mcnt;
  bit mtick;

  led_pattern_gen #(
    .WAIT_TIME (W),
    .LED_COUNT (4),
    .ACTIVE_LOW(1'b1)
  ) dut_a (
    .in_clk  (clk),
    .in_rst  (rst),
    .in_mode (mode),
    .in_pause(pause),
    .in_step (step),
    .out_led (led_a),
    .out_tick(tick_a)
  );

  led_pattern_gen #(
    .WAIT_TIME (W),
    .LED_COUNT (1),
    .ACTIVE_LOW(1'b0)
  ) dut_b (
    .in_clk  (clk),
    .in_rst  (rst),
    .in_mode (mode),
    .in_pause(pause),
    .in_step (step),
    .out_led (led_b),
    .out_tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern after k advances since the mode's start value.
  function automatic longint ref_pat(int m, int k, int n);
    longint md;
    longint g;
    int per;
    int p;
    md = longint'(1) << n;
    case (m)
      0: return k % md;
      1: return md - 1 - (k % md);
      3: begin
        g = k % md;
        return g ^ (g >> 1);
      end
      default: begin
        if (n == 1) return 1;
        per = 2 * (n - 1);
        p = k % per;
        return longint'(1) << ((p < n) ? p : per - p);
      end
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [63:0] pa;
    logic [63:0] pb;
    logic [3:0]  ea;
    pa = 64'(ref_pat(mm, mk, 4));
    pb = 64'(ref_pat(mm, mk, 1));
    ea = ~pa[3:0];
    check({tag, "_led_a"}, 32'(led_a), 32'(ea));
    check({tag, "_led_b"}, 32'(led_b), 32'(pb[0]));
    check({tag, "_tick_a"}, 32'(tick_a), 32'(mtick));
    check({tag, "_tick_b"}, 32'(tick_b), 32'(mtick));
  endtask

  task automatic model_reset();
    mm    = 0;
    mk    = 0;
    mcnt  = 0;
    mtick = 1'b0;
  endtask

  task automatic model_edge(int m, bit p, bit s);
    bit adv;
    if (m != mm) begin
      mm    = m;
      mk    = 0;
      mcnt  = 0;
      mtick = 1'b0;
    end else begin
      adv = p ? s : (mcnt == W);
      if (adv) begin
        mk++;
        mcnt  = 0;
        mtick = 1'b1;
      end else begin
        mtick = 1'b0;
        if (!p) mcnt++;
      end
    end
  endtask

  task automatic cyc(int m, bit p, bit s);
    mode  = m[1:0];
    pause = p;
    step  = s;
    @(posedge clk);
    model_edge(m, p, s);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset(int m);
    mode  = m[1:0];
    pause = 1'b0;
    step  = 1'b0;
    rst   = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] cur;
    int rm;
    bit rp;
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    mode  = 2'd0;
    pause = 1'b0;
    step  = 1'b0;
    #1;

    do_reset(0);
    check("rst_led_all_ones", 32'(led_a), 32'hF);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    check("pre_first_adv", 32'(led_a), 32'hF);
    cyc(0, 0, 0);
    check("first_adv_led", 32'(led_a), 32'hE);
    check("first_adv_tick", 32'(tick_a), 32'h1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);

    cyc(1, 0, 0);
    check("down_start", 32'(led_a), 32'h0);
    for (int i = 0; i < 72; i++) cyc(1, 0, 0);

    cyc(2, 0, 0);
    for (int i = 0; i < 40; i++) cyc(2, 0, 0);

    cyc(3, 0, 0);
    prev = 4'h0;
    for (int i = 0; i < 40; i++) begin
      cyc(3, 0, 0);
      if (tick_a) begin
        cur = ~led_a;
        check("gray_one_bit", 32'($countones(prev ^ cur)), 32'd1);
        prev = cur;
      end
    end

    cyc(0, 0, 0);
    for (int i = 0; i < 10 && mcnt != 2; i++) cyc(0, 0, 0);
    check("pause_at_cnt2", 32'(mcnt), 32'd2);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0);
    cyc(0, 1, 1);
    check("step_tick", 32'(tick_a), 32'h1);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);

    for (int i = 0; i < 10 && mcnt != W; i++) cyc(0, 0, 0);
    check("chg_at_max", 32'(mcnt), 32'(W));
    cyc(2, 0, 0);
    check("chg_no_tick", 32'(tick_a), 32'h0);
    check("chg_bounce_start", 32'(led_a), 32'hE);
    for (int i = 0; i < 8; i++) cyc(2, 0, 0);

    rm = 2;
    rp = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15, 0) == 0) rm = int'($urandom_range(3, 0));
      if ($urandom_range(7, 0) == 0) rp = ~rp;
      cyc(rm, rp, $urandom_range(3, 0) == 0);
    end

    cyc(1, 0, 0);
    cyc(1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_led_a", 32'(led_a), 32'hF);
    check("async_rst_led_b", 32'(led_b), 32'h0);
    check("async_rst_tick", 32'(tick_a), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check_all("async_rst_hold");
    #2;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) cyc(0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
